ahb_sram_slave: RTL and testbench
=================================

# ahb_sram_slave

Single-port on-chip SRAM responder for the core's simple AHB-style request bus. It sits on the slave side of the core's `ahb_*` port group. It accepts one request at a time, inserts a programmable number of wait states, commits writes with byte or halfword lane masking, and returns read data with a one-cycle valid pulse.

## Interface
- `ADDR_W`, default 10: word-address bits; the array holds 2^ADDR_W 32-bit words, 4 KB at default.
- `WAIT_STATES`, default 1: busy cycles inserted between accept and completion; legal range 0..15.
- `clk` input 1: single clock, all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ahb_en` input 1: request strobe, sampled only while `ahb_busy`=0.
- `ahb_wr_en` input 1: 1 = write, 0 = read.
- `ahb_addr` input 32: byte address; bits [ADDR_W+1:2] index the array; upper bits are ignored.
- `ahb_wr_data` input 32: write data, right-justified for byte and halfword sizes.
- `ahb_data_size` input 2: 00 = byte, 01 = halfword, 10 = word, 11 = treated as word.
- `ahb_rd_data` output 32: read data, right-justified and zero-extended.
- `ahb_rd_vld` output 1: one-cycle pulse qualifying `ahb_rd_data`.
- `ahb_busy` output 1: high while a request is in flight.
- `misalign` output 1: sticky misaligned-access flag; tied 0 without the macro.

## Operation
- The FSM has three states: IDLE, WAIT, DONE.
- **Accept:** an accept occurs at any edge where `ahb_en`=1 and the FSM is in IDLE or DONE. At accept, addr, wr_en, wr_data and size are latched into request registers. Inputs are don't-care afterwards.
- **After accept:**
  - WAIT_STATES>0: go to WAIT and load wait counter = WAIT_STATES-1.
  - WAIT_STATES=0: go directly to DONE.
- **WAIT:** the counter decrements each cycle. When it reaches 0, go to DONE.
- **DONE:** lasts one cycle.
  - Writes commit to the array at the edge entering DONE.
  - For reads, `ahb_rd_vld`=1 and `ahb_rd_data` is valid throughout DONE.
  - Exit to IDLE, or back-to-back to WAIT/DONE if a new accept occurs at the DONE edge.
- `ahb_en` while in WAIT is ignored. It is not queued.
- **Write lane mask:**
  - Byte: lane addr[1:0] gets wr_data[7:0].
  - Halfword: lane addr[1] gets wr_data[15:0].
  - Word: all lanes.
  - Unselected lanes keep their old value.
- **Read extraction:**
  - Byte: word >> (8*addr[1:0]), masked to 8 bits.
  - Halfword: word >> (16*addr[1]), masked to 16 bits.
  - Upper bits are zero.
- Without the macro, misaligned addresses are not checked: halfword uses addr[1], word ignores addr[1:0].
- The array is not reset. Contents after reset are undefined.

## Timing
- **Reset values:**
  - `ahb_busy`=0, `ahb_rd_vld`=0, `ahb_rd_data`=0, `misalign`=0.
  - FSM = IDLE, wait counter = 0.
- **Busy:** `ahb_busy`=1 exactly in WAIT. It is 0 in IDLE and DONE.
- **Read latency:** with accept at edge k, `ahb_rd_vld` is high in the cycle after edge k+WAIT_STATES. This is 1 cycle after accept for WAIT_STATES=0, 2 cycles at default.
- **Back-to-back:** throughput is one request per WAIT_STATES+1 cycles.
- **Outside DONE:** `ahb_rd_data` holds its last read value. `ahb_rd_vld` stays 0 for writes.
- **Reset mid-operation:** `rst` asserted in WAIT aborts the request. A pending write is never committed, and no `ahb_rd_vld` pulse is produced.

## Configuration
- `AHB_SRAM_MISALIGN_CHK_EN`, defined: misaligned requests are detected at accept. A request is misaligned if it is a halfword with addr[0]=1, or a word/size-11 with addr[1:0]≠0.
  - A misaligned write is dropped; the array is unchanged.
  - A misaligned read returns 32'hDEAD_BEEF in DONE.
  - `misalign` is set sticky until `rst`.
  - FSM timing and handshake are identical to an aligned request.
- `AHB_SRAM_MISALIGN_CHK_EN`, undefined: no check is made, `misalign` is tied 0, and accesses proceed as described in Operation.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle -> all outputs 0 immediately, FSM = IDLE.
- **Word write and read:** word write 32'h1234_5678 @0x10, then word read @0x10, default WAIT_STATES=1 -> `ahb_busy` high 1 cycle per request; `ahb_rd_vld` pulses 2 cycles after the read accept with 32'h1234_5678.
- **Byte write:** byte write 8'hAB @0x13 over the word above, then word read @0x10 -> 32'hAB34_5678. Byte read @0x11 -> 32'h0000_0056.
- **Ignored requests and back-to-back:** WAIT_STATES=3, pulse `ahb_en` during WAIT -> ignored, busy high 3 cycles. A new request presented in DONE is accepted back-to-back.
- **Reset abort:** assert `rst` during WAIT of a word write 32'hFFFF_FFFF @0x20 (prior content 0) -> a later read of @0x20 returns 0, with no spurious `ahb_rd_vld`.
- **Misalignment (macro defined):** halfword write @0x21 -> array unchanged, `misalign`=1. Word read @0x22 -> 32'hDEAD_BEEF. With the macro undefined, `misalign` stays 0.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - single-port SRAM responder with programmable wait states
// Optional misaligned-access detection: define AHB_SRAM_MISALIGN_CHK_EN.
module ahb_sram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ahb_en,
    input  logic        ahb_wr_en,
    input  logic [31:0] ahb_addr,
    input  logic [31:0] ahb_wr_data,
    input  logic [1:0]  ahb_data_size,
    output logic [31:0] ahb_rd_data,
    output logic        ahb_rd_vld,
    output logic        ahb_busy,
    output logic        misalign
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [31:0] mem [2**ADDR_W];

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt, wait_cnt_nxt;
    logic              accept;
    logic [ADDR_W+1:0] req_addr, cur_addr;
    logic              req_wr, cur_wr;
    logic [31:0]       req_data, cur_data;
    logic [1:0]        req_size, cur_size;
    logic              cur_mis;
    logic              enter_done;
    logic              mem_we;
    logic [3:0]        byte_en;
    logic [31:0]       wr_lanes;
    logic [31:0]       rd_word, rd_shift_b, rd_shift_h, rd_next;
    logic              unused_addr_bits;

    assign unused_addr_bits = &{1'b0, ahb_addr[31:ADDR_W+2]};

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        accept       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (ahb_en) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt    = S_WAIT;
                        wait_cnt_nxt = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_DONE;
                else                  wait_cnt_nxt = wait_cnt - 4'd1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // With zero wait states the request completes on its own accept edge,
    // so the live inputs are used instead of the latched copy.
    assign cur_addr   = accept ? ahb_addr[ADDR_W+1:0] : req_addr;
    assign cur_wr     = accept ? ahb_wr_en : req_wr;
    assign cur_data   = accept ? ahb_wr_data : req_data;
    assign cur_size   = accept ? ahb_data_size : req_size;
    assign enter_done = (state_nxt == S_DONE);

`ifdef AHB_SRAM_MISALIGN_CHK_EN
    logic mis_flag;
    assign cur_mis = (cur_size == 2'b01) ? cur_addr[0]
                                         : (cur_size[1] && (cur_addr[1:0] != 2'b00));
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                     mis_flag <= 1'b0;
        else if (accept && cur_mis)  mis_flag <= 1'b1;
    end
    assign misalign = mis_flag;
`else
    assign cur_mis  = 1'b0;
    assign misalign = 1'b0;
`endif

    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = cur_data;
        case (cur_size)
            2'b00: begin
                byte_en  = 4'b0001 << cur_addr[1:0];
                wr_lanes = {4{cur_data[7:0]}};
            end
            2'b01: begin
                byte_en  = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{cur_data[15:0]}};
            end
            default: byte_en = 4'b1111;
        endcase
    end

    assign mem_we = enter_done && cur_wr && !cur_mis && !rst;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[cur_addr[ADDR_W+1:2]][8*i +: 8] <= wr_lanes[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_word    = mem[cur_addr[ADDR_W+1:2]];
        rd_shift_b = rd_word >> {cur_addr[1:0], 3'b000};
        rd_shift_h = rd_word >> {cur_addr[1], 4'b0000};
        case (cur_size)
            2'b00:   rd_next = {24'h0, rd_shift_b[7:0]};
            2'b01:   rd_next = {16'h0, rd_shift_h[15:0]};
            default: rd_next = rd_word;
        endcase
        if (cur_mis) rd_next = 32'hDEAD_BEEF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 4'd0;
            req_addr    <= '0;
            req_wr      <= 1'b0;
            req_data    <= 32'h0;
            req_size    <= 2'b00;
            ahb_rd_data <= 32'h0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                req_addr <= cur_addr;
                req_wr   <= cur_wr;
                req_data <= cur_data;
                req_size <= cur_size;
            end
            if (enter_done && !cur_wr) ahb_rd_data <= rd_next;
        end
    end

    assign ahb_busy   = (state == S_WAIT);
    assign ahb_rd_vld = (state == S_DONE) && !req_wr;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - bench for ahb_sram_slave at WAIT_STATES 1 (default) and 3
module tb_ahb_sram_slave;

    localparam int WS0 = 1;
    localparam int WS1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en      [2];
    logic        wr_en   [2];
    logic [31:0] addr    [2];
    logic [31:0] wr_data [2];
    logic [1:0]  size    [2];
    logic [31:0] rd_data [2];
    logic        rd_vld  [2];
    logic        busy    [2];
    logic        mis     [2];

    int errors = 0;
    int checks = 0;

    logic [31:0] ref_mem [2][1024];
    logic [31:0] last_rd [2];
    logic        mis_exp [2];

    always #5 clk = ~clk;

    ahb_sram_slave u_dut0 (
        .clk(clk), .rst(rst), .ahb_en(en[0]), .ahb_wr_en(wr_en[0]), .ahb_addr(addr[0]),
        .ahb_wr_data(wr_data[0]), .ahb_data_size(size[0]), .ahb_rd_data(rd_data[0]),
        .ahb_rd_vld(rd_vld[0]), .ahb_busy(busy[0]), .misalign(mis[0])
    );

    ahb_sram_slave #(.WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .rst(rst), .ahb_en(en[1]), .ahb_wr_en(wr_en[1]), .ahb_addr(addr[1]),
        .ahb_wr_data(wr_data[1]), .ahb_data_size(size[1]), .ahb_rd_data(rd_data[1]),
        .ahb_rd_vld(rd_vld[1]), .ahb_busy(busy[1]), .misalign(mis[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mis(input logic [31:0] a, input logic [1:0] sz);
`ifdef AHB_SRAM_MISALIGN_CHK_EN
        if (sz == 2'd1) return a[0];
        if (sz >= 2'd2) return a[1:0] != 2'b00;
`endif
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_read(input int d, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] w;
        w = ref_mem[d][a[11:2]];
        if (is_mis(a, sz)) return 32'hDEAD_BEEF;
        case (sz)
            2'd0:    return (w >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
            2'd1:    return (w >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            default: return w;
        endcase
    endfunction

    task automatic m_write(input int d, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] w;
        int lane;
        if (is_mis(a, sz)) return;
        w = ref_mem[d][a[11:2]];
        case (sz)
            2'd0: begin
                lane = int'(a[1:0]);
                w[8*lane +: 8] = wd[7:0];
            end
            2'd1: begin
                lane = 2 * int'(a[1]);
                w[8*lane +: 16] = wd[15:0];
            end
            default: w = wd;
        endcase
        ref_mem[d][a[11:2]] = w;
    endtask

    task automatic reset_model();
        for (int d = 0; d < 2; d++) begin
            last_rd[d] = 32'h0;
            mis_exp[d] = 1'b0;
        end
    endtask

    task automatic drive(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [1:0] sz);
        en[d] = 1'b1; wr_en[d] = wr; addr[d] = a; wr_data[d] = wd; size[d] = sz;
    endtask

    task automatic req(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input bit pulse, output logic [31:0] got);
        int ws;
        logic [31:0] exp;
        ws  = (d == 0) ? WS0 : WS1;
        exp = m_read(d, a, sz);
        @(negedge clk);
        drive(d, wr, a, wd, sz);
        @(posedge clk); #1;
        en[d] = 1'b0;
        if (is_mis(a, sz)) mis_exp[d] = 1'b1;
        for (int i = 0; i < ws; i++) begin
            chk($sformatf("busy_in_wait d%0d c%0d", d, i), 32'(busy[d]), 32'd1);
            chk($sformatf("no_vld_in_wait d%0d c%0d", d, i), 32'(rd_vld[d]), 32'd0);
            if (pulse && i == 0) drive(d, 1'b1, a, 32'hFFFF_FFFF, 2'd2);
            if (i == 1) en[d] = 1'b0;
            @(posedge clk); #1;
        end
        chk($sformatf("busy_in_done d%0d", d), 32'(busy[d]), 32'd0);
        chk($sformatf("misalign d%0d", d), 32'(mis[d]), 32'(mis_exp[d]));
        if (wr) begin
            chk($sformatf("no_vld_write d%0d", d), 32'(rd_vld[d]), 32'd0);
            chk($sformatf("rd_data_hold d%0d", d), rd_data[d], last_rd[d]);
            m_write(d, a, wd, sz);
        end else begin
            chk($sformatf("vld_read d%0d", d), 32'(rd_vld[d]), 32'd1);
            chk($sformatf("rd_data d%0d a=%h sz=%0d", d, a, sz), rd_data[d], exp);
            last_rd[d] = exp;
        end
        got = rd_data[d];
        @(posedge clk); #1;
        chk($sformatf("vld_drop d%0d", d), 32'(rd_vld[d]), 32'd0);
        chk($sformatf("idle_not_busy d%0d", d), 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  sz;
        bit          wr;
        for (int d = 0; d < 2; d++) begin
            en[d] = 1'b0; wr_en[d] = 1'b0; addr[d] = 32'h0; wr_data[d] = 32'h0; size[d] = 2'd0;
        end
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("reset_busy d%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("reset_vld d%0d", d), 32'(rd_vld[d]), 32'd0);
            chk($sformatf("reset_rd_data d%0d", d), rd_data[d], 32'd0);
            chk($sformatf("reset_misalign d%0d", d), 32'(mis[d]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        req(0, 1'b1, 32'h10, 32'h1234_5678, 2'd2, 1'b0, got);
        req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, got);
        chk("word_read_0x10", got, 32'h1234_5678);
        req(0, 1'b1, 32'h13, 32'h0000_00AB, 2'd0, 1'b0, got);
        req(0, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, got);
        chk("word_after_byte_write", got, 32'hAB34_5678);
        req(0, 1'b0, 32'h11, 32'h0, 2'd0, 1'b0, got);
        chk("byte_read_0x11", got, 32'h0000_0056);
        req(0, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, got);

        // asynchronous reset in the middle of a cycle
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        reset_model();
        chk("async_rst_rd_data", rd_data[0], 32'h0);
        chk("async_rst_vld", 32'(rd_vld[0]), 32'd0);
        chk("async_rst_busy", 32'(busy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        req(0, 1'b1, 32'h20, 32'h0, 2'd2, 1'b0, got);
        @(negedge clk);
        drive(0, 1'b1, 32'h20, 32'hFFFF_FFFF, 2'd2);
        @(posedge clk); #1;
        en[0] = 1'b0;
        chk("abort_busy_before_rst", 32'(busy[0]), 32'd1);
        #2 rst = 1'b1;
        #1;
        reset_model();
        chk("abort_busy_after_rst", 32'(busy[0]), 32'd0);
        chk("abort_vld_after_rst", 32'(rd_vld[0]), 32'd0);
        @(posedge clk); #1;
        chk("abort_vld_held_rst", 32'(rd_vld[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("abort_vld_after_release", 32'(rd_vld[0]), 32'd0);
        chk("abort_busy_after_release", 32'(busy[0]), 32'd0);
        req(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, got);
        chk("abort_not_committed", got, 32'h0);

        req(0, 1'b1, 32'h21, 32'h0000_1357, 2'd1, 1'b0, got);
        req(0, 1'b0, 32'h22, 32'h0, 2'd2, 1'b0, got);
`ifdef AHB_SRAM_MISALIGN_CHK_EN
        chk("misaligned_word_read", got, 32'hDEAD_BEEF);
        chk("misalign_sticky", 32'(mis[0]), 32'd1);
        req(0, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, got);
        chk("misaligned_write_dropped", got, 32'h0);
`else
        chk("unchecked_word_read", got, 32'h0000_1357);
        chk("misalign_tied_low", 32'(mis[0]), 32'd0);
`endif

        // wait-state-3 instance: request during WAIT ignored, then back-to-back
        req(1, 1'b1, 32'h44, 32'h1111_2222, 2'd2, 1'b0, got);
        req(1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b1, got);
        chk("ignored_in_wait_read", got, 32'h1111_2222);
        req(1, 1'b0, 32'h44, 32'h0, 2'd2, 1'b0, got);
        chk("ignored_in_wait_no_write", got, 32'h1111_2222);

        @(negedge clk);
        drive(1, 1'b1, 32'h40, 32'hCAFE_F00D, 2'd2);
        @(posedge clk); #1;
        en[1] = 1'b0;
        for (int i = 0; i < WS1; i++) begin
            chk($sformatf("b2b_wr_busy c%0d", i), 32'(busy[1]), 32'd1);
            @(posedge clk); #1;
        end
        chk("b2b_wr_done_busy", 32'(busy[1]), 32'd0);
        m_write(1, 32'h40, 32'hCAFE_F00D, 2'd2);
        drive(1, 1'b0, 32'h40, 32'h0, 2'd2);
        @(posedge clk); #1;
        en[1] = 1'b0;
        for (int i = 0; i < WS1; i++) begin
            chk($sformatf("b2b_rd_busy c%0d", i), 32'(busy[1]), 32'd1);
            chk($sformatf("b2b_rd_no_vld c%0d", i), 32'(rd_vld[1]), 32'd0);
            @(posedge clk); #1;
        end
        chk("b2b_rd_vld", 32'(rd_vld[1]), 32'd1);
        chk("b2b_rd_data", rd_data[1], 32'hCAFE_F00D);
        last_rd[1] = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("b2b_vld_drop", 32'(rd_vld[1]), 32'd0);

        for (int d = 0; d < 2; d++) begin
            for (int w = 0; w < 8; w++)
                req(d, 1'b1, 32'h80 + 32'(4 * w), $urandom(), 2'd2, 1'b0, got);
            for (int n = 0; n < 40; n++) begin
                a  = ($urandom() & 32'hFFFF_F000) | (32'h80 + 32'($urandom_range(0, 31)));
                sz = 2'($urandom_range(0, 3));
                wr = 1'($urandom_range(0, 1));
                req(d, wr, a, $urandom(), sz, 1'b0, got);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
